kcn_chunk_sequencer: RTL and testbench

// Parametrised key/nonce/counter acquisition sequencer for the cipher core, run once per block after start.

---
 rtl/kcn_chunk_sequencer_if.sv | 32 +++
 rtl/kcn_chunk_sequencer.sv | 152 +++++++++++++++
 tb/tb_kcn_chunk_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kcn_chunk_sequencer_if.sv
// Chunk/TRNG handshake bundle for kcn_chunk_sequencer.
//   master : the sequencer (drives requests, consumes words)
//   slave  : the word source (drives chunk/TRNG words, consumes requests)
// Signals:
//   chunk_type/chunk_valid/chunk : offered chunk word and its field type
//   chunk_request/request_type/chunk_index : word currently wanted
//   trng_data/trng_ready         : random word, valid this cycle
//   trng_request                 : sequencer wants random words
interface kcn_chunk_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 5
);
  logic [1:0]        chunk_type;
  logic              chunk_valid;
  logic [WORD_W-1:0] chunk;
  logic              chunk_request;
  logic [1:0]        request_type;
  logic [IDX_W-1:0]  chunk_index;
  logic [WORD_W-1:0] trng_data;
  logic              trng_ready;
  logic              trng_request;

  modport master (
    input  chunk_type, chunk_valid, chunk, trng_data, trng_ready,
    output chunk_request, request_type, chunk_index, trng_request
  );

  modport slave (
    output chunk_type, chunk_valid, chunk, trng_data, trng_ready,
    input  chunk_request, request_type, chunk_index, trng_request
  );
endinterface

// File: rtl/kcn_chunk_sequencer.sv
// Key/nonce/counter acquisition sequencer for the cipher core.
// After start, each field is either requested word-by-word over the chunk
// interface (LSB word first) or taken from a default (key, counter) / the
// TRNG (nonce). Assembled fields are presented with params_valid; a word
// that does not arrive within TIMEOUT_CYCLES raises a sticky error.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        begin acquisition (ignored while busy)
//   use_streamed_key/nonce/counter  field source selects
//   default_key, default_counter fallback field values
//   cif (master)                 chunk + TRNG handshake
//   key_out, nonce_out, counter_out  assembled fields
//   params_valid                 fields complete, held until start/rst
//   busy                         acquisition in progress
//   error                        timeout, sticky until start/rst
module kcn_chunk_sequencer #(
  parameter int WORD_W         = 32,
  parameter int KEY_WORDS      = 8,
  parameter int NONCE_WORDS    = 3,
  parameter int CTR_WORDS      = 1,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          use_streamed_key,
  input  logic                          use_streamed_nonce,
  input  logic                          use_streamed_counter,
  input  logic [KEY_WORDS*WORD_W-1:0]   default_key,
  input  logic [CTR_WORDS*WORD_W-1:0]   default_counter,
  kcn_chunk_sequencer_if.master         cif,
  output logic [KEY_WORDS*WORD_W-1:0]   key_out,
  output logic [NONCE_WORDS*WORD_W-1:0] nonce_out,
  output logic [CTR_WORDS*WORD_W-1:0]   counter_out,
  output logic                          params_valid,
  output logic                          busy,
  output logic                          error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] KEY_LAST   = IDX_W'(KEY_WORDS - 1);
  localparam logic [IDX_W-1:0] NONCE_LAST = IDX_W'(NONCE_WORDS - 1);
  localparam logic [IDX_W-1:0] CTR_LAST   = IDX_W'(CTR_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_NONCE_CH, S_NONCE_RNG, S_CTR, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [TMR_W-1:0]  timer_q;
  // Source selects for the later fields are captured at start so that a
  // change on the inputs mid-acquisition cannot reroute the sequence.
  logic              cfg_nonce_q, cfg_ctr_q;

  logic              req, trng_req, busy_c;
  logic [1:0]        req_type;
  logic [IDX_W-1:0]  last_idx;
  logic              accept, is_last, timeout, start_ok;
  logic [WORD_W-1:0] word_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    req_type = 2'b00;
    trng_req = 1'b0;
    busy_c   = 1'b0;
    last_idx = '0;
    case (state_q)
      S_KEY:       begin req = 1'b1; req_type = 2'b00; busy_c = 1'b1; last_idx = KEY_LAST;   end
      S_NONCE_CH:  begin req = 1'b1; req_type = 2'b01; busy_c = 1'b1; last_idx = NONCE_LAST; end
      S_NONCE_RNG: begin trng_req = 1'b1;              busy_c = 1'b1; last_idx = NONCE_LAST; end
      S_CTR:       begin req = 1'b1; req_type = 2'b10; busy_c = 1'b1; last_idx = CTR_LAST;   end
      default: ;
    endcase

    // Mismatched or unrequested chunk words simply fall through here.
    accept   = (req && cif.chunk_valid && (cif.chunk_type == req_type)) ||
               (trng_req && cif.trng_ready);
    word_c   = trng_req ? cif.trng_data : cif.chunk;
    is_last  = accept && (idx_q == last_idx);
    timeout  = busy_c && !accept && (timer_q == TMR_LAST);
    start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

    if (start_ok) begin
      if (use_streamed_key)        state_d = S_KEY;
      else if (use_streamed_nonce) state_d = S_NONCE_CH;
      else                         state_d = S_NONCE_RNG;
    end else if (timeout) begin
      state_d = S_ERR;
    end else if (is_last) begin
      case (state_q)
        S_KEY:                  state_d = cfg_nonce_q ? S_NONCE_CH : S_NONCE_RNG;
        S_NONCE_CH, S_NONCE_RNG: state_d = cfg_ctr_q ? S_CTR : S_DONE;
        S_CTR:                  state_d = S_DONE;
        default:                state_d = state_q;
      endcase
    end
  end

  assign cif.chunk_request = req;
  assign cif.request_type  = req_type;
  assign cif.chunk_index   = req ? idx_q : '0;
  assign cif.trng_request  = trng_req;
  assign busy              = busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      timer_q      <= '0;
      cfg_nonce_q  <= 1'b0;
      cfg_ctr_q    <= 1'b0;
      key_out      <= '0;
      nonce_out    <= '0;
      counter_out  <= '0;
      params_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      // Status flags follow the state being entered, so both appear on the
      // first cycle of DONE/ERR and clear on the edge that leaves them.
      params_valid <= (state_d == S_DONE);
      error        <= (state_d == S_ERR);
      if (start_ok) begin
        idx_q       <= '0;
        timer_q     <= '0;
        cfg_nonce_q <= use_streamed_nonce;
        cfg_ctr_q   <= use_streamed_counter;
        if (!use_streamed_key)     key_out     <= default_key;
        if (!use_streamed_counter) counter_out <= default_counter;
      end else if (accept) begin
        idx_q   <= is_last ? '0 : idx_q + 1'b1;
        timer_q <= '0;
        case (state_q)
          S_KEY:                   key_out[idx_q*WORD_W +: WORD_W]     <= word_c;
          S_NONCE_CH, S_NONCE_RNG: nonce_out[idx_q*WORD_W +: WORD_W]   <= word_c;
          S_CTR:                   counter_out[idx_q*WORD_W +: WORD_W] <= word_c;
          default: ;
        endcase
      end else if (busy_c) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kcn_chunk_sequencer.sv
module tb_kcn_chunk_sequencer;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;
  localparam int TMO    = 16;

  localparam logic [255:0] KEY_A   = {128'hDEADBEEF_CAFEF00D_01020304_05060708,
                                      128'hDEADBEEF_CAFEF00D_01020304_05060708};
  localparam logic [255:0] KEY_B   = 256'h11223344_55667788_99AABBCC_DDEEFF00_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [255:0] KEY_C   = 256'hC0000007_C0000006_C0000005_C0000004_C0000003_C0000002_C0000001_C0000000;
  localparam logic [255:0] DEF_KEY = 256'hD0D0D0D7_D0D0D0D6_D0D0D0D5_D0D0D0D4_D0D0D0D3_D0D0D0D2_D0D0D0D1_D0D0D0D0;
  localparam logic [95:0]  NONCE_A = 96'h12345678_9ABCDEF0_FEDCBA98;
  localparam logic [95:0]  NONCE_T = 96'h33333333_22222222_11111111;
  localparam logic [95:0]  NONCE_R = 96'hC0C0C0C2_B0B0B0B1_A0A0A0A0;
  localparam logic [31:0]  CTR_A   = 32'hA0B0C0D0;
  localparam logic [31:0]  DEF_CTR = 32'h0000CAFE;

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic         pv;
    logic         err;
  } exp_t;

  logic clk, rst, start;
  logic use_key, use_nonce, use_ctr;
  logic [255:0] default_key;
  logic [31:0]  default_counter;
  logic [255:0] key_out;
  logic [95:0]  nonce_out;
  logic [31:0]  counter_out;
  logic params_valid, busy, error;

  kcn_chunk_sequencer_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) cif ();

  kcn_chunk_sequencer #(
    .WORD_W(WORD_W), .KEY_WORDS(8), .NONCE_WORDS(3), .CTR_WORDS(1),
    .IDX_W(IDX_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .use_streamed_key(use_key), .use_streamed_nonce(use_nonce),
    .use_streamed_counter(use_ctr),
    .default_key(default_key), .default_counter(default_counter),
    .cif(cif),
    .key_out(key_out), .nonce_out(nonce_out), .counter_out(counter_out),
    .params_valid(params_valid), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  bit   watch_nonce = 0;
  int   viol = 0;
  logic pv_prev = 1'b0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_req(input logic [1:0] t, input int i, output bit ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cif.chunk_request && cif.request_type == t && cif.chunk_index == IDX_W'(i)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("wait_req type %0d idx %0d", t, i));
  endtask

  task automatic put_word(input logic [1:0] t, input logic [31:0] w);
    cif.chunk_type  = t;
    cif.chunk_valid = 1'b1;
    cif.chunk       = w;
    @(posedge clk);
    #1 cif.chunk_valid = 1'b0;
  endtask

  task automatic stream(input logic [1:0] t, input logic [255:0] val, input int first, input int last);
    bit ok;
    for (int i = first; i <= last; i++) begin
      wait_req(t, i, ok);
      if (!ok) return;
      put_word(t, val[i*32 +: 32]);
    end
  endtask

  task automatic trng_word(input logic [31:0] w, input int gap);
    bit ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cif.trng_request) begin ok = 1; break; end
    end
    if (!ok) begin fail_now("wait trng_request"); return; end
    repeat (gap) @(negedge clk);
    cif.trng_ready = 1'b1;
    cif.trng_data  = w;
    @(posedge clk);
    #1 cif.trng_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " key_out"}, key_out, '0);
    check({tag, " nonce_out"}, nonce_out, '0);
    check({tag, " counter_out"}, counter_out, '0);
    check({tag, " params_valid"}, params_valid, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " error"}, error, 0);
    check({tag, " chunk_request"}, cif.chunk_request, 0);
    check({tag, " trng_request"}, cif.trng_request, 0);
    check({tag, " request_type"}, cif.request_type, 0);
    check({tag, " chunk_index"}, cif.chunk_index, 0);
  endtask

  task automatic push_exp(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                          input logic pv, input logic err);
    exp_t e;
    e.key = k; e.nonce = n; e.ctr = c; e.pv = pv; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (watch_nonce && cif.chunk_request && cif.request_type == 2'b01) viol++;
      if (!rst && ((params_valid && !pv_prev) || (error && !err_prev))) begin
        if (exp_q.size() == 0) begin
          fail_now("scoreboard unexpected completion");
        end else begin
          e = exp_q.pop_front();
          check("sb key_out", key_out, e.key);
          check("sb nonce_out", nonce_out, e.nonce);
          check("sb counter_out", counter_out, e.ctr);
          check("sb params_valid", params_valid, e.pv);
          check("sb error", error, e.err);
        end
      end
      pv_prev  = params_valid;
      err_prev = error;
    end
  endtask

  initial begin
    logic [255:0] partial;
    int cyc;

    rst = 1'b1; start = 1'b0;
    use_key = 1'b1; use_nonce = 1'b1; use_ctr = 1'b1;
    default_key = DEF_KEY; default_counter = DEF_CTR;
    cif.chunk_type = 2'b00; cif.chunk_valid = 1'b0; cif.chunk = '0;
    cif.trng_data = '0; cif.trng_ready = 1'b0;

    fork
      monitor_loop();
      begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // All fields streamed.
    push_exp(KEY_A, NONCE_A, CTR_A, 1'b1, 1'b0);
    pulse_start();
    check("t1 busy after start", busy, 1);
    check("t1 chunk_index after start", cif.chunk_index, 0);
    stream(2'b00, KEY_A, 0, 7);
    stream(2'b01, {160'h0, NONCE_A}, 0, 2);
    check("t1 params_valid before ctr", params_valid, 0);
    stream(2'b10, {224'h0, CTR_A}, 0, 0);
    check("t1 params_valid after last ctr", params_valid, 1);
    check("t1 busy after last ctr", busy, 0);

    // Wrong chunk type mid-key is dropped.
    push_exp(KEY_B, NONCE_A, CTR_A, 1'b1, 1'b0);
    pulse_start();
    stream(2'b00, KEY_B, 0, 2);
    begin
      bit ok;
      wait_req(2'b00, 3, ok);
      put_word(2'b01, 32'hBADBAD00);
    end
    check("t2 chunk_index after bad type", cif.chunk_index, 3);
    check("t2 request_type after bad type", cif.request_type, 2'b00);
    stream(2'b00, KEY_B, 3, 7);
    stream(2'b01, {160'h0, NONCE_A}, 0, 2);
    stream(2'b10, {224'h0, CTR_A}, 0, 0);
    check("t2 params_valid", params_valid, 1);

    // Nonce from TRNG with gaps.
    use_nonce = 1'b0;
    push_exp(KEY_A, NONCE_T, CTR_A, 1'b1, 1'b0);
    watch_nonce = 1;
    pulse_start();
    stream(2'b00, KEY_A, 0, 7);
    trng_word(32'h11111111, 2);
    trng_word(32'h22222222, 1);
    trng_word(32'h33333333, 3);
    stream(2'b10, {224'h0, CTR_A}, 0, 0);
    check("t3 params_valid", params_valid, 1);
    check("t3 nonce_out", nonce_out, NONCE_T);
    watch_nonce = 0;
    check("t3 nonce chunk requests", viol, 0);
    use_nonce = 1'b1;

    // Timeout after key word 2.
    partial = KEY_A;
    partial[95:0] = KEY_C[95:0];
    push_exp(partial, NONCE_T, CTR_A, 1'b0, 1'b1);
    pulse_start();
    stream(2'b00, KEY_C, 0, 2);
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 cyc++;
      if (error) break;
    end
    check("t4 timeout latency", cyc, TMO);
    check("t4 busy after error", busy, 0);
    check("t4 params_valid after error", params_valid, 0);
    check("t4 chunk_request after error", cif.chunk_request, 0);
    pulse_start();
    check("t4 error cleared by start", error, 0);
    check("t4 busy after restart", busy, 1);

    // Reset in the middle of the key.
    stream(2'b00, KEY_C, 0, 4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_all_zero("t5 mid rst");
    @(negedge clk) rst = 1'b0;
    pulse_start();
    check("t5 chunk_request", cif.chunk_request, 1);
    check("t5 request_type", cif.request_type, 2'b00);
    check("t5 chunk_index", cif.chunk_index, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Nothing streamed, start held through acquisition.
    use_key = 1'b0; use_nonce = 1'b0; use_ctr = 1'b0;
    push_exp(DEF_KEY, NONCE_R, DEF_CTR, 1'b1, 1'b0);
    @(negedge clk) start = 1'b1;
    trng_word(32'hA0A0A0A0, 1);
    check("t6 busy with start held", busy, 1);
    check("t6 key_out default", key_out, DEF_KEY);
    trng_word(32'hB0B0B0B1, 2);
    check("t6 busy with start held 2", busy, 1);
    start = 1'b0;
    trng_word(32'hC0C0C0C2, 1);
    check("t6 params_valid", params_valid, 1);
    check("t6 counter_out default", counter_out, DEF_CTR);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
